// File: rtl/pipeline_elastic_buffer.sv
// pipeline_elastic_buffer: ready/valid buffer with a DEPTH-entry circular store.
// input_ready and output_valid are derived from the registered count only, so
// there is no combinational path between the upstream and downstream handshakes.
// Words are written at the write pointer and presented from the read pointer;
// both pointers wrap at DEPTH-1, so DEPTH need not be a power of two.
module pipeline_elastic_buffer #(
  parameter int WORD_WIDTH  = 8,
  parameter int DEPTH       = 4,
  parameter int COUNT_WIDTH = 3
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   input_valid,
  output logic                   input_ready,
  input  logic [WORD_WIDTH-1:0]  input_data,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic [WORD_WIDTH-1:0]  output_data,
  output logic [COUNT_WIDTH-1:0] occupancy
);

  localparam int                     PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]       PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_FULL = COUNT_WIDTH'(DEPTH);

  // Advance a pointer, wrapping from the last entry back to entry 0.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  logic [WORD_WIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   wr_fire;
  logic                   rd_fire;

  assign input_ready  = (count_q != CNT_FULL);
  assign output_valid = (count_q != '0);
  assign occupancy    = count_q;
  assign output_data  = mem_q[rd_ptr_q];

  assign wr_fire = input_valid & input_ready;
  assign rd_fire = output_valid & output_ready;

  // Next-state for pointers and count; a concurrent read and write leave count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = ptr_next(wr_ptr_q);
    if (rd_fire) rd_ptr_d = ptr_next(rd_ptr_q);
    if (wr_fire && !rd_fire)      count_d = count_q + 1'b1;
    else if (!wr_fire && rd_fire) count_d = count_q - 1'b1;
  end

  // Control state register; clear overrides any handshake in the same cycle.
  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage: zeroed on clear so output_data reads 0 after reset; written only on an accepted word.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_fire) begin
      mem_q[wr_ptr_q] <= input_data;
    end
  end

endmodule

// File: tb/tb_pipeline_elastic_buffer.sv
// Directed bench for pipeline_elastic_buffer: DEPTH=4, DEPTH=3 and DEPTH=1 instances
// share one clock and clear; expected values are hand-derived or from a bench-side count.
module tb_pipeline_elastic_buffer;

  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  // DEPTH=4 instance
  logic       a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
  logic [7:0] a_in_data = '0, a_out_data;
  logic [2:0] a_occ;
  // DEPTH=3 instance
  logic       b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
  logic [7:0] b_in_data = '0, b_out_data;
  logic [1:0] b_occ;
  // DEPTH=1 instance
  logic       c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b0;
  logic [7:0] c_in_data = '0, c_out_data;
  logic [0:0] c_occ;

  pipeline_elastic_buffer #(.WORD_WIDTH(8), .DEPTH(4), .COUNT_WIDTH(3)) dut_a (
    .clock(clock), .clear(clear),
    .input_valid(a_in_valid), .input_ready(a_in_ready), .input_data(a_in_data),
    .output_valid(a_out_valid), .output_ready(a_out_ready), .output_data(a_out_data),
    .occupancy(a_occ));

  pipeline_elastic_buffer #(.WORD_WIDTH(8), .DEPTH(3), .COUNT_WIDTH(2)) dut_b (
    .clock(clock), .clear(clear),
    .input_valid(b_in_valid), .input_ready(b_in_ready), .input_data(b_in_data),
    .output_valid(b_out_valid), .output_ready(b_out_ready), .output_data(b_out_data),
    .occupancy(b_occ));

  pipeline_elastic_buffer #(.WORD_WIDTH(8), .DEPTH(1), .COUNT_WIDTH(1)) dut_c (
    .clock(clock), .clear(clear),
    .input_valid(c_in_valid), .input_ready(c_in_ready), .input_data(c_in_data),
    .output_valid(c_out_valid), .output_ready(c_out_ready), .output_data(c_out_data),
    .occupancy(c_occ));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Step past the next rising edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int sent, rcv, cyc, cnt;
    logic wr, rd;
    logic [7:0] exp_words [4];

    // 1. Reset then idle
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("rst_in_ready", a_in_ready, 1);
    check_eq("rst_out_valid", a_out_valid, 0);
    check_eq("rst_occ", a_occ, 0);
    check_eq("rst_out_data", a_out_data, 0);
    tick();
    check_eq("idle_occ", a_occ, 0);

    // 2. Fill to full with downstream stalled
    a_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'(8'h11 * (i + 1));
      tick();
      check_eq("fill_occ", a_occ, i + 1);
      check_eq("fill_head", a_out_data, 8'h11);
    end
    check_eq("full_in_ready", a_in_ready, 0);
    a_in_data = 8'h55;
    tick();
    check_eq("full_reject_occ", a_occ, 4);
    check_eq("full_hold_valid", a_out_valid, 1);
    check_eq("full_hold_data", a_out_data, 8'h11);

    // 3. Read from full while offering 0x55: read fires, write does not
    a_out_ready = 1'b1;
    check_eq("drain_first", a_out_data, 8'h11);
    tick();
    a_out_ready = 1'b0;
    check_eq("drain_occ", a_occ, 3);
    check_eq("drain_in_ready", a_in_ready, 1);
    check_eq("drain_head", a_out_data, 8'h22);
    tick();
    a_in_valid = 1'b0;
    check_eq("refill_occ", a_occ, 4);
    exp_words[0] = 8'h22; exp_words[1] = 8'h33; exp_words[2] = 8'h44; exp_words[3] = 8'h55;
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("order_valid", a_out_valid, 1);
      check_eq("order_data", a_out_data, exp_words[i]);
      tick();
    end
    a_out_ready = 1'b0;
    check_eq("empty_occ", a_occ, 0);
    check_eq("empty_valid", a_out_valid, 0);

    // 4. Streaming 100 words at full rate
    sent = 0; rcv = 0; cyc = 0;
    a_in_valid = 1'b1; a_in_data = 8'd0; a_out_ready = 1'b1;
    while (rcv < 100 && cyc < 300) begin
      if (a_out_valid && a_out_ready) begin
        check_eq("stream_data", a_out_data, rcv);
        rcv++;
      end
      wr = a_in_valid && a_in_ready;
      tick();
      cyc++;
      if (wr) begin
        sent++;
        check_eq("stream_occ", a_occ, 1);
      end
      a_in_valid = (sent < 100);
      a_in_data  = 8'(sent);
    end
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    check_eq("stream_count", rcv, 100);
    check_eq("stream_cycles", cyc, 101);
    check_eq("stream_end_occ", a_occ, 0);

    // 5a. DEPTH=3: 10 words under random stalls, crossing pointer wrap
    sent = 0; rcv = 0; cyc = 0; cnt = 0;
    b_in_data = 8'hA0;
    while (rcv < 10 && cyc < 400) begin
      b_in_valid  = (sent < 10) && ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 2) != 0);
      #1;
      check_eq("d3_in_ready", b_in_ready, (cnt != 3));
      check_eq("d3_out_valid", b_out_valid, (cnt != 0));
      rd = b_out_valid && b_out_ready;
      if (rd) begin
        check_eq("d3_data", b_out_data, 8'hA0 + rcv);
        rcv++;
      end
      wr = b_in_valid && b_in_ready;
      tick();
      cyc++;
      if (wr) sent++;
      cnt = cnt + (wr ? 1 : 0) - (rd ? 1 : 0);
      check_eq("d3_occ", b_occ, cnt);
      b_in_data = 8'(8'hA0 + sent);
    end
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    check_eq("d3_count", rcv, 10);

    // 5b. DEPTH=1: continuous valid/ready transfers only every other cycle
    sent = 0; rcv = 0;
    c_in_valid = 1'b1; c_out_ready = 1'b1; c_in_data = 8'h30;
    for (int i = 0; i < 10; i++) begin
      check_eq("d1_in_ready", c_in_ready, (i % 2 == 0));
      check_eq("d1_out_valid", c_out_valid, (i % 2 == 1));
      if (c_out_valid) begin
        check_eq("d1_data", c_out_data, 8'h30 + rcv);
        rcv++;
      end
      wr = c_in_valid && c_in_ready;
      tick();
      if (wr) sent++;
      c_in_data = 8'(8'h30 + sent);
    end
    c_in_valid = 1'b0; c_out_ready = 1'b0;
    check_eq("d1_writes", sent, 5);
    check_eq("d1_reads", rcv, 5);

    // 6. Clear mid-stream with a word offered in the clear cycle
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'hA1; tick();
    a_in_data = 8'hA2; tick();
    check_eq("mid_occ_before", a_occ, 2);
    clear = 1'b1; a_in_data = 8'hEE;
    tick();
    clear = 1'b0; a_in_valid = 1'b0;
    check_eq("mid_clr_occ", a_occ, 0);
    check_eq("mid_clr_valid", a_out_valid, 0);
    check_eq("mid_clr_ready", a_in_ready, 1);
    check_eq("mid_clr_data", a_out_data, 0);
    a_in_valid = 1'b1; a_in_data = 8'h5A;
    tick();
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    check_eq("post_clr_occ", a_occ, 1);
    check_eq("post_clr_data", a_out_data, 8'h5A);
    tick();
    check_eq("post_clr_empty", a_out_valid, 0);
    a_out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
